// File: rtl/ofmap_post_proc_pkg.sv
// Shared accelerator defines for the output-feature-map post-processor:
// sizing constants, widths, FSM encoding, request structs and the requantiser.
package ofmap_post_proc_pkg;

  localparam int TILE_MAX_DEF   = 64;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PSUM3_W        = 32;
  localparam int PSUM1_W        = 24;
  localparam int ID_W           = 8;
  localparam int OUT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0]  tile_len;
    logic [5:0]  pass_num;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        identity_en;
  } cfg_t;

  typedef struct packed {
    logic [PSUM3_W-1:0] p3;
    logic [PSUM1_W-1:0] p1;
    logic [ID_W-1:0]    id;
  } beat_t;

  // Bias, round-half-up right shift in 33 bits so the rounding add cannot wrap,
  // then clamp to the non-negative int8 range.
  function automatic logic [OUT_W-1:0] requant(input logic [31:0] acc,
                                               input logic [31:0] bias,
                                               input logic [4:0]  shift);
    logic [31:0]        t;
    logic signed [32:0] t33;
    logic signed [32:0] rnd;
    logic signed [32:0] r;
    t   = acc + bias;
    t33 = signed'({t[31], t});
    rnd = (shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift - 5'd1));
    r   = (t33 + rnd) >>> shift;
    if (r < 33'sd0)        return 8'd0;
    else if (r > 33'sd127) return 8'd127;
    else                   return r[7:0];
  endfunction

endpackage

// File: rtl/ofmap_post_proc_fifo.sv
// Synchronous output FIFO with occupancy count; read data is forced to zero
// while empty so the output bus is clean out of reset.
module ofmap_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ofmap_post_proc.sv
// Output-feature-map post-processor: multi-pass psum accumulation over a tile,
// bias + shift requantisation to int8, and an output FIFO with ready/valid.
module ofmap_post_proc
  import ofmap_post_proc_pkg::*;
#(
  parameter int TILE_MAX   = TILE_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         cfg_tile_len,
  input  logic [5:0]         cfg_pass_num,
  input  logic [31:0]        cfg_bias,
  input  logic [4:0]         cfg_shift,
  input  logic               cfg_identity_en,
  input  logic               psum_valid,
  input  logic [PSUM3_W-1:0] psum_3x3,
  input  logic [PSUM1_W-1:0] psum_1x1,
  input  logic [ID_W-1:0]    identity,
  output logic               in_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int AW = (TILE_MAX > 1) ? $clog2(TILE_MAX) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_e        state, state_nx;
  cfg_t          cfg;
  beat_t         beat;
  logic [6:0]    pix_cnt;
  logic [5:0]    pass_cnt;
  logic [AW-1:0] pix_idx;
  logic [31:0]   acc_buf [TILE_MAX];

  logic          start_ok, accept, drop;
  logic          first_pass, last_pass, last_pix;
  logic [31:0]   sum, acc;
  logic          s1_valid;
  logic [31:0]   s1_acc;
  logic [OUT_W-1:0] s2_data;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  logic          fifo_empty;

  assign beat       = '{p3: psum_3x3, p1: psum_1x1, id: identity};
  assign start_ok   = start && (state == ST_IDLE);
  assign accept     = psum_valid && in_ready;
  assign drop       = psum_valid && !in_ready;
  assign first_pass = (pass_cnt == 6'd0);
  assign last_pass  = (pass_cnt == cfg.pass_num - 6'd1);
  assign last_pix   = (pix_cnt == cfg.tile_len - 7'd1);
  assign pix_idx    = pix_cnt[AW-1:0];

  // Identity joins only on the final pass so it is added exactly once per pixel.
  assign sum = beat.p3 + {{(32-PSUM1_W){beat.p1[PSUM1_W-1]}}, beat.p1}
             + ((cfg.identity_en && last_pass) ? {{(32-ID_W){beat.id[ID_W-1]}}, beat.id} : 32'd0);
  assign acc = first_pass ? sum : acc_buf[pix_idx] + sum;

  // S2 is combinational into the FIFO, so only S1 and the FIFO hold results
  // and the occupancy check below reserves a FIFO slot for each of them.
  assign occ      = {1'b0, fifo_cnt} + (CW+1)'(s1_valid);
  assign in_ready = (state == ST_RUN) && (occ < (CW+1)'(FIFO_DEPTH));
  assign busy     = (state != ST_IDLE);
  assign s2_data  = requant(s1_acc, cfg.bias, cfg.shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      pix_cnt  <= '0;
      pass_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        cfg      <= '{tile_len: cfg_tile_len, pass_num: cfg_pass_num, bias: cfg_bias,
                      shift: cfg_shift, identity_en: cfg_identity_en};
        pix_cnt  <= '0;
        pass_cnt <= '0;
      end else if (accept) begin
        if (last_pix) begin
          pix_cnt  <= '0;
          pass_cnt <= pass_cnt + 6'd1;
        end else begin
          pix_cnt  <= pix_cnt + 7'd1;
        end
      end
      if (start_ok)  err <= 1'b0;
      else if (drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_acc   <= '0;
    end else begin
      s1_valid <= accept && last_pass;
      if (accept && last_pass) s1_acc <= acc;
    end
  end

  // Left unreset: pass 0 always overwrites before any read.
  always_ff @(posedge clk) begin
    if (accept && !last_pass) acc_buf[pix_idx] <= acc;
  end

  ofmap_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .wdata (s2_data),
    .pop   (out_valid && out_ready),
    .rdata (out_data),
    .cnt   (fifo_cnt),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (accept && last_pass && last_pix) state_nx = ST_DRAIN;
      ST_DRAIN: if (!s1_valid && fifo_empty) begin
                  done     = 1'b1;
                  state_nx = ST_IDLE;
                end
      default:  state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ofmap_post_proc.sv
// Directed bench for ofmap_post_proc: hand-computed outputs, backpressure,
// error flag and mid-run reset.
module tb_ofmap_post_proc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  cfg_tile_len = '0;
  logic [5:0]  cfg_pass_num = '0;
  logic [31:0] cfg_bias = '0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_identity_en = 1'b0;
  logic        psum_valid = 1'b0;
  logic [31:0] psum_3x3 = '0;
  logic [23:0] psum_1x1 = '0;
  logic [7:0]  identity = '0;
  logic        in_ready, out_valid, busy, done, err;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  ofmap_post_proc #(.TILE_MAX(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_tile_len(cfg_tile_len), .cfg_pass_num(cfg_pass_num), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_identity_en(cfg_identity_en),
    .psum_valid(psum_valid), .psum_3x3(psum_3x3), .psum_1x1(psum_1x1), .identity(identity),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] got_q[$];
  int         exp_q[$];
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         got_base = 0;

  // Monitor mid-cycle: a pop/accept seen here happens at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (psum_valid && in_ready) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_start(input int tl, input int pn, input int bias, input int sh, input logic ide);
    cfg_tile_len    = 7'(tl);
    cfg_pass_num    = 6'(pn);
    cfg_bias        = 32'(bias);
    cfg_shift       = 5'(sh);
    cfg_identity_en = ide;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int p3, input int p1, input int id);
    int w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 1);
      return;
    end
    psum_valid = 1'b1;
    psum_3x3   = 32'(p3);
    psum_1x1   = 24'(p1);
    identity   = 8'(id);
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (!done && w < 300) begin
      tick();
      w++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic cmp_out(input string tag);
    logic [31:0] g;
    chk({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      g = (got_base + i < got_q.size()) ? 32'(got_q[got_base + i]) : 32'hdead_beef;
      chk($sformatf("%s_out[%0d]", tag, i), g, 32'(exp_q[i]));
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    // Reset state
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;
    tick();

    // Single pass passthrough, plus first-output latency
    d0 = done_cnt;
    run_start(4, 1, 0, 0, 1'b0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_in_ready", 32'(in_ready), 1);
    send(10, 0, 0);
    chk("t1_lat_n1", 32'(out_valid), 0);
    tick();
    chk("t1_lat_n2", 32'(out_valid), 1);
    chk("t1_lat_data", 32'(out_data), 10);
    send(20, 0, 0);
    send(30, 0, 0);
    send(40, 0, 0);
    wait_done("t1");
    exp_q = '{10, 20, 30, 40};
    cmp_out("t1");
    chk("t1_done_pulses", 32'(done_cnt - d0), 1);

    // Three passes with identity on the last: 80+80+85=245, (245+2)>>>2=61
    run_start(2, 3, 0, 2, 1'b1);
    repeat (6) send(100, -20, 5);
    wait_done("t2");
    exp_q = '{61, 61};
    cmp_out("t2");

    // Saturation at both ends
    run_start(2, 1, 0, 0, 1'b0);
    send(-50, 0, 0);
    send(1000, 0, 0);
    wait_done("t3");
    exp_q = '{0, 127};
    cmp_out("t3");

    // Bias + rounding: pix0 36+7=43 ->(47)>>>3=5; pix1 67+7=74 ->(78)>>>3=9
    run_start(2, 2, 7, 3, 1'b0);
    send(20, 0, 0);
    send(-3, 0, 0);
    send(15, 1, 0);
    send(100, -30, 0);
    wait_done("t3b");
    exp_q = '{5, 9};
    cmp_out("t3b");

    // Backpressure: only FIFO_DEPTH beats admitted while out_ready is low
    out_ready = 1'b0;
    run_start(8, 1, 0, 0, 1'b0);
    d0 = acc_cnt;
    for (int i = 1; i <= 4; i++) send(i, 0, 0);
    tick(3);
    chk("t4_in_ready_low", 32'(in_ready), 0);
    chk("t4_accepted", 32'(acc_cnt - d0), 4);
    chk("t4_head_valid", 32'(out_valid), 1);
    chk("t4_head_data", 32'(out_data), 1);
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(i, 0, 0);
    wait_done("t4");
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    cmp_out("t4");

    // Dropped beat sets err without advancing; start mid-run is ignored
    out_ready = 1'b0;
    run_start(6, 1, 0, 0, 1'b0);
    chk("t5_err_clear", 32'(err), 0);
    for (int i = 1; i <= 4; i++) send(i, 0, 0);
    chk("t5_blocked", 32'(in_ready), 0);
    psum_valid = 1'b1;
    psum_3x3   = 32'd99;
    tick();
    psum_valid = 1'b0;
    chk("t5_err_set", 32'(err), 1);
    run_start(1, 1, 0, 4, 1'b0);
    chk("t5_start_ign_busy", 32'(busy), 1);
    chk("t5_start_ign_err", 32'(err), 1);
    out_ready = 1'b1;
    send(5, 0, 0);
    send(6, 0, 0);
    wait_done("t5");
    exp_q = '{1, 2, 3, 4, 5, 6};
    cmp_out("t5");
    chk("t5_err_sticky", 32'(err), 1);
    run_start(1, 1, 0, 0, 1'b0);
    chk("t5_err_cleared", 32'(err), 0);
    send(3, 0, 0);
    wait_done("t5b");
    exp_q = '{3};
    cmp_out("t5b");

    // Reset in pass 1 of 3, then a fresh run must not see stale partial sums
    run_start(2, 3, 0, 2, 1'b1);
    repeat (3) send(100, -20, 5);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_out_data", 32'(out_data), 0);
    chk("t6_rst_err", 32'(err), 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    got_base = got_q.size();
    run_start(2, 3, 1, 0, 1'b0);
    repeat (6) send(10, 0, 0);
    wait_done("t6");
    exp_q = '{31, 31};
    cmp_out("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
